// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad controller with frame-level debounce.
// Drives one row low at a time (two cycles per row), samples the columns on the
// second cycle of each row slot, reduces each frame to NONE / KEY(code) / MULTI and
// accepts a candidate once it has been stable for DEBOUNCE_FRAMES frames.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe keyPress while a
// single key stays held (first after REPEAT_DELAY frames, then every REPEAT_PERIOD).
module keypad_scanner #(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 4,
   parameter int unsigned DEBOUNCE_FRAMES = 3,
   parameter int unsigned REPEAT_DELAY    = 50,
   parameter int unsigned REPEAT_PERIOD   = 10
) (
   input  logic                          clk_100Hz,
   input  logic                          reset,
   input  logic [COLS-1:0]               keypadCol,
   output logic [ROWS-1:0]               keypadRow,
   output logic [$clog2(ROWS*COLS)-1:0]  keyCode,
   output logic                          keyValid,
   output logic                          keyPress,
   output logic                          keyRelease,
   output logic                          multiKey
);

   localparam int unsigned CODE_W  = $clog2(ROWS * COLS);
   localparam int unsigned ROW_W   = $clog2(ROWS);
   localparam int unsigned COL_W   = $clog2(COLS);
   localparam int unsigned MATCH_W = $clog2(DEBOUNCE_FRAMES + 1);

   localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [MATCH_W-1:0] DEB_MAX  = MATCH_W'(DEBOUNCE_FRAMES);

   // Reject nonsensical configurations at elaboration time.
   if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 ||
       DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   // Accepted / candidate keypad state.
   typedef enum logic [1:0] {
      StNone  = 2'd0,
      StKey   = 2'd1,
      StMulti = 2'd2
   } kstate_e;

   // Scan position.
   logic [ROW_W-1:0]   row_q;
   logic               phase_q;
   logic [ROW_W-1:0]   row_next;

   // Partial-frame accumulation: hits saturate at 2 (meaning "more than one").
   logic [1:0]         hits_q;
   logic [CODE_W-1:0]  low_q;

   // Debounce history.
   kstate_e            prev_kind_q;
   logic [CODE_W-1:0]  prev_code_q;
   logic [MATCH_W-1:0] match_q;
   kstate_e            acc_q;

   // Per-row decode of the column lines.
   logic [1:0]         row_hits;
   logic [COL_W-1:0]   row_low;
   logic [CODE_W-1:0]  row_code;

   // Frame reduction including the row being sampled this cycle.
   logic [1:0]         frame_hits;
   logic [CODE_W-1:0]  frame_low;
   kstate_e            cand_kind;
   logic [CODE_W-1:0]  cand_code;
   logic               cand_same;
   logic [MATCH_W-1:0] match_next;
   logic               frame_end;
   logic               accept;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_q;
   logic             rep_first_q;
   logic [REP_W-1:0] rep_thr;
   logic             rep_fire;
`endif

   // Count pressed columns in the active row (saturating) and find the lowest one.
   always_comb begin
      row_hits = 2'd0;
      row_low  = '0;
      for (int c = int'(COLS) - 1; c >= 0; c--) begin
         if (!keypadCol[c]) begin
            row_low = COL_W'(c);
            if (row_hits != 2'd2) begin
               row_hits = row_hits + 2'd1;
            end
         end
      end
   end

   // Merge this row into the frame and form the candidate / debounce decision.
   always_comb begin
      row_code   = CODE_W'(int'(row_q) * int'(COLS) + int'(row_low));
      frame_hits = hits_q;
      frame_low  = low_q;
      if (row_hits != 2'd0) begin
         // Rows arrive in ascending order, so the first hit is the lowest code.
         if (hits_q == 2'd0) begin
            frame_low = row_code;
         end
         frame_hits = (hits_q == 2'd0 && row_hits == 2'd1) ? 2'd1 : 2'd2;
      end

      case (frame_hits)
         2'd0: begin
            cand_kind = StNone;
            cand_code = '0;
         end
         2'd1: begin
            cand_kind = StKey;
            cand_code = frame_low;
         end
         default: begin
            cand_kind = StMulti;
            cand_code = '0;
         end
      endcase

      cand_same  = (cand_kind == prev_kind_q) && (cand_code == prev_code_q);
      match_next = cand_same ? ((match_q == DEB_MAX) ? match_q : match_q + MATCH_W'(1))
                             : MATCH_W'(1);
      frame_end  = phase_q && (row_q == LAST_ROW);
      // A KEY candidate only differs from an accepted KEY if the code differs.
      accept     = (match_next >= DEB_MAX) &&
                   !((cand_kind == acc_q) && (cand_kind != StKey || cand_code == keyCode));
      row_next   = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Repeat threshold: long initial hold, then the shorter period.
   always_comb begin
      rep_thr  = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);
      rep_fire = (rep_q + REP_W'(1)) >= rep_thr;
   end
`endif

   // Scan sequencer, debounce state machine and registered outputs.
   always_ff @(posedge clk_100Hz) begin
      if (reset) begin
         row_q       <= '0;
         phase_q     <= 1'b0;
         keypadRow   <= ~ROWS'(1);
         hits_q      <= 2'd0;
         low_q       <= '0;
         prev_kind_q <= StNone;
         prev_code_q <= '0;
         match_q     <= '0;
         acc_q       <= StNone;
         keyCode     <= '0;
         keyValid    <= 1'b0;
         keyPress    <= 1'b0;
         keyRelease  <= 1'b0;
         multiKey    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
         rep_first_q <= 1'b1;
`endif
      end else begin
         keyPress   <= 1'b0;
         keyRelease <= 1'b0;
         phase_q    <= ~phase_q;

         if (phase_q) begin
            row_q     <= row_next;
            keypadRow <= ~(ROWS'(1) << row_next);

            if (frame_end) begin
               hits_q      <= 2'd0;
               low_q       <= '0;
               prev_kind_q <= cand_kind;
               prev_code_q <= cand_code;
               match_q     <= match_next;

               if (accept) begin
                  acc_q <= cand_kind;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_q       <= '0;
                  rep_first_q <= 1'b1;
`endif
                  case (cand_kind)
                     StNone: begin
                        keyRelease <= keyValid;
                        keyValid   <= 1'b0;
                        multiKey   <= 1'b0;
                     end
                     StKey: begin
                        keyPress   <= 1'b1;
                        keyRelease <= keyValid;
                        keyCode    <= cand_code;
                        keyValid   <= 1'b1;
                        multiKey   <= 1'b0;
                     end
                     default: begin
                        keyRelease <= keyValid;
                        keyValid   <= 1'b0;
                        multiKey   <= 1'b1;
                     end
                  endcase
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (acc_q == StKey) begin
                  if (rep_fire) begin
                     keyPress    <= 1'b1;
                     rep_q       <= '0;
                     rep_first_q <= 1'b0;
                  end else begin
                     rep_q <= rep_q + REP_W'(1);
                  end
               end
`endif
            end else begin
               hits_q <= frame_hits;
               low_q  <= frame_low;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level reference model of the keypad scanner, a table of
// directed scenarios with independently derived end results, an 80-frame hold for
// auto-repeat, a mid-frame reset and randomized key sequences.
module tb_keypad_scanner;

   localparam int DEB  = 3;
   localparam int RDLY = 50;
   localparam int RPER = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int EXP_HOLD_PRESSES = 4;
`else
   localparam int EXP_HOLD_PRESSES = 1;
`endif

   logic       clk_100Hz = 1'b0;
   logic       reset     = 1'b1;
   logic [3:0] keypadCol;
   logic [3:0] keypadRow;
   logic [3:0] keyCode;
   logic       keyValid, keyPress, keyRelease, multiKey;
   logic [15:0] held = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int cnt_press, cnt_rel;

   // Reference model: candidate encoding -1 = NONE, -2 = MULTI, else key code.
   int m_prev, m_run, m_acc, m_code, m_frame, m_acc_frame;
   bit m_press, m_rel;

   always #5 clk_100Hz = ~clk_100Hz;

   keypad_scanner dut (
      .clk_100Hz (clk_100Hz),
      .reset     (reset),
      .keypadCol (keypadCol),
      .keypadRow (keypadRow),
      .keyCode   (keyCode),
      .keyValid  (keyValid),
      .keyPress  (keyPress),
      .keyRelease(keyRelease),
      .multiKey  (multiKey)
   );

   // Physical matrix: a held key pulls its column low while its row is driven low.
   always_comb begin
      keypadCol = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!keypadRow[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (held[r*4+c]) keypadCol[c] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int cand_of(input logic [15:0] m);
      if ($countones(m) == 0) return -1;
      if ($countones(m) > 1) return -2;
      for (int k = 0; k < 16; k++) if (m[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = -1; m_run = 0; m_acc = -1; m_code = 0;
      m_press = 0; m_rel = 0; m_frame = 0; m_acc_frame = 0; cyc = 0;
   endtask

   task automatic model_frame_end(input logic [15:0] m);
      int c;
      int d;
      c = cand_of(m);
      m_press = 0;
      m_rel   = 0;
      m_run   = (c == m_prev) ? ((m_run < DEB) ? m_run + 1 : m_run) : 1;
      m_prev  = c;
      if (m_run >= DEB && c != m_acc) begin
         m_rel = (m_acc >= 0);
         if (c >= 0) begin
            m_press = 1;
            m_code  = c;
         end
         m_acc       = c;
         m_acc_frame = m_frame;
      end else if (m_acc >= 0) begin
         d = m_frame - m_acc_frame;
`ifdef KEYPAD_AUTOREPEAT_EN
         if (d == RDLY || (d > RDLY && (d - RDLY) % RPER == 0)) m_press = 1;
`endif
      end
      m_frame++;
   endtask

   // Hold mask m for one full frame, checking every cycle against the model.
   task automatic run_frame(input logic [15:0] m);
      logic [3:0] exp_row;
      held = m;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_100Hz);
         exp_row = ~(4'b0001 << ((cyc / 2) % 4));
         check("keypadRow", keypadRow, exp_row);
         check("keyPress", keyPress, (i == 0) && m_press);
         check("keyRelease", keyRelease, (i == 0) && m_rel);
         check("keyValid", keyValid, m_acc >= 0);
         check("multiKey", multiKey, m_acc == -2);
         check("keyCode", keyCode, m_code);
         if (keyPress) cnt_press++;
         if (keyRelease) cnt_rel++;
         @(posedge clk_100Hz);
         #1;
         cyc++;
      end
      model_frame_end(m);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_100Hz);
      #1;
      @(negedge clk_100Hz);
      check("rst_keypadRow", keypadRow, 4'b1110);
      check("rst_keyCode", keyCode, 0);
      check("rst_flags", {keyValid, keyPress, keyRelease, multiKey}, 4'b0000);
      @(posedge clk_100Hz);
      #1;
      reset = 1'b0;
      model_reset();
      cnt_press = 0;
      cnt_rel   = 0;
   endtask

   typedef struct {
      string       name;
      logic [15:0] m1;
      int          f1;
      logic [15:0] m2;
      int          f2;
      int          press;
      int          rel;
      bit          valid;
      int          code;
      bit          multi;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{"press_release_9", 16'h0200, 4, 16'h0000, 4, 1, 1, 0,  9, 0};
      vecs[1] = '{"short_5",         16'h0020, 2, 16'h0000, 4, 0, 0, 0,  0, 0};
      vecs[2] = '{"multi_held",      16'h0021, 3, 16'h0000, 2, 0, 0, 0,  0, 1};
      vecs[3] = '{"multi_released",  16'h0021, 3, 16'h0000, 4, 0, 0, 0,  0, 0};
      vecs[4] = '{"switch_9_12",     16'h0200, 4, 16'h1000, 4, 2, 1, 1, 12, 0};
      vecs[5] = '{"key_to_multi",    16'h0200, 4, 16'h0208, 4, 1, 1, 0,  9, 1};
      vecs[6] = '{"held_15",         16'h8000, 4, 16'h0000, 2, 1, 0, 1, 15, 0};
      vecs[7] = '{"glitch_0",        16'h0001, 1, 16'h0000, 3, 0, 0, 0,  0, 0};

      model_reset();
      held = '0;
      repeat (2) @(posedge clk_100Hz);
      do_reset();

      foreach (vecs[v]) begin
         do_reset();
         for (int f = 0; f < vecs[v].f1; f++) run_frame(vecs[v].m1);
         for (int f = 0; f < vecs[v].f2; f++) run_frame(vecs[v].m2);
         check({vecs[v].name, "_presses"}, cnt_press, vecs[v].press);
         check({vecs[v].name, "_releases"}, cnt_rel, vecs[v].rel);
         check({vecs[v].name, "_valid"}, keyValid, vecs[v].valid);
         check({vecs[v].name, "_code"}, keyCode, vecs[v].code);
         check({vecs[v].name, "_multi"}, multiKey, vecs[v].multi);
      end

      // Long hold of key 3: auto-repeat pulses (if built in), then one release.
      do_reset();
      for (int f = 0; f < 80; f++) run_frame(16'h0008);
      for (int f = 0; f < 4; f++) run_frame(16'h0000);
      check("hold3_presses", cnt_press, EXP_HOLD_PRESSES);
      check("hold3_releases", cnt_rel, 1);
      check("hold3_code", keyCode, 3);

      // Reset in the middle of a frame while a key is accepted and held.
      do_reset();
      for (int f = 0; f < 4; f++) run_frame(16'h0200);
      repeat (3) @(posedge clk_100Hz);
      #1;
      do_reset();
      for (int f = 0; f < 4; f++) run_frame(16'h0200);
      check("midreset_presses", cnt_press, 1);
      check("midreset_releases", cnt_rel, 0);

      // Randomized segments: none, single keys and key pairs held for 1..5 frames.
      do_reset();
      for (int s = 0; s < 24; s++) begin
         logic [15:0] m;
         int          kind;
         int          nf;
         kind = int'($urandom_range(0, 3));
         nf   = int'($urandom_range(1, 5));
         m    = '0;
         if (kind == 1 || kind == 2) begin
            m[$urandom_range(0, 15)] = 1'b1;
         end else if (kind == 3) begin
            m[$urandom_range(0, 15)] = 1'b1;
            m[$urandom_range(0, 15)] = 1'b1;
         end
         for (int f = 0; f < nf; f++) run_frame(m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, meaning number of driven row lines (2..8).
REQ-002 The block SHALL have parameter COLS, default 4, meaning number of sensed column lines (2..8).
REQ-003 The block SHALL have parameter DEBOUNCE_FRAMES, default 3, meaning consecutive identical scan frames required to accept a state (1..15).
REQ-004 The block SHALL have parameters REPEAT_DELAY, default 50, and REPEAT_PERIOD, default 10, meaning auto-repeat hold time and interval in frames.
REQ-005 The block SHALL have port clk_100Hz, input, 1 bit: the one clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port keypadCol, input, COLS bits: column sense lines, active low.
REQ-008 The block SHALL have port keypadRow, output, ROWS bits: row drive lines, exactly one bit low at any time.
REQ-009 The block SHALL have port keyCode, output, clog2(ROWS*COLS) bits: accepted key index.
REQ-010 The block SHALL have port keyValid, output, 1 bit: high while an accepted single key is held.
REQ-011 The block SHALL have port keyPress, output, 1 bit: one-cycle press strobe.
REQ-012 The block SHALL have port keyRelease, output, 1 bit: one-cycle release strobe.
REQ-013 The block SHALL have port multiKey, output, 1 bit: high while an accepted multi-key state exists.

Function
REQ-014 Each row SHALL be driven low for 2 cycles, rows 0..ROWS-1 in order, wrapping; one frame is 2*ROWS cycles.
REQ-015 Columns SHALL be sampled on the second cycle of each row slot; a low bit c in row r marks key code r*COLS+c.
REQ-016 Per frame, the block SHALL count pressed keys and capture the lowest pressed code; frame candidate = NONE (0 keys), KEY(code) (1 key), or MULTI (>1 keys).
REQ-017 At each frame end, if the candidate equals the previous frame's candidate, the match counter SHALL increment (saturating), else reset to 1.
REQ-018 When the match counter reaches DEBOUNCE_FRAMES and candidate differs from the accepted state, the accepted state SHALL update in the cycle after that frame end.
REQ-019 On an accepted transition NONE->KEY(k): keyPress=1 for one cycle, keyCode=k, keyValid=1.
REQ-020 On KEY(k)->NONE: keyRelease=1 for one cycle, keyValid=0, keyCode holds k.
REQ-021 On KEY(a)->KEY(b): keyRelease and keyPress SHALL pulse in the same cycle, keyCode=b, keyValid stays 1.
REQ-022 On any transition into MULTI: multiKey=1, keyValid=0, keyRelease pulses if keyValid was 1; keyPress never pulses for MULTI.
REQ-023 On MULTI->NONE or MULTI->KEY(k): multiKey=0; KEY(k) behaves as REQ-019.
REQ-024 A candidate seen for fewer than DEBOUNCE_FRAMES consecutive frames SHALL cause no output change.

Reset
REQ-025 While reset is high at a clock edge: keypadRow = all ones except bit 0 low, row slot 0 phase 0, keyCode=0, keyValid=0, keyPress=0, keyRelease=0, multiKey=0, accepted state NONE, match counter 0, repeat counter 0.
REQ-026 Reset asserted mid-frame or mid-hold SHALL discard the partial frame and emit no strobes; scanning restarts from row 0 the cycle after reset deasserts.

Configuration
REQ-027 Macro KEYPAD_AUTOREPEAT_EN, when defined, SHALL add auto-repeat: while accepted KEY(k) persists, keyPress re-pulses (keyCode unchanged) after REPEAT_DELAY frames, then every REPEAT_PERIOD frames; the counter clears on any accepted change.
REQ-028 Without KEYPAD_AUTOREPEAT_EN, keyPress SHALL pulse exactly once per accepted press, and REPEAT_DELAY/REPEAT_PERIOD SHALL be unused.

Verification (defaults ROWS=4, COLS=4, DEBOUNCE_FRAMES=3; frame = 8 cycles)
REQ-029 Reset release, no key -> keypadRow cycles 1110,1110,1101,1101,1011,1011,0111,0111; all strobes 0; keyValid 0.
REQ-030 Hold row 2 col 1 (keypadCol=1101 when keypadRow=1011) from frame 0 -> keyPress once, 1 cycle after frame 2 end; keyCode=9, keyValid=1; release -> keyRelease 3 frames later, keyCode stays 9.
REQ-031 Key 5 pressed for 2 frames, then released -> no keyPress, no keyRelease.
REQ-032 Keys 0 and 5 held together for 3 frames -> multiKey=1, keyValid=0, no keyPress; release both -> multiKey=0 after 3 NONE frames.
REQ-033 Hold key 9 to acceptance, then switch directly to key 12 -> keyPress and keyRelease in the same cycle, keyCode=12.
REQ-034 With KEYPAD_AUTOREPEAT_EN, hold key 3 for 80 frames -> keyPress at acceptance, at +50 frames, then +60 and +70; without the macro -> single keyPress.
